// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared defaults, state encoding and helpers for the FIFO write-port arbiter.
// Macro defaults may be overridden on the tool command line.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef WR_ARB_NUM_REQ
`define WR_ARB_NUM_REQ 4
`endif
`ifndef WR_ARB_MAX_BEATS
`define WR_ARB_MAX_BEATS 16
`endif
`ifndef ARB_IDLE
`define ARB_IDLE 1'b0
`endif
`ifndef ARB_BUSY
`define ARB_BUSY 1'b1
`endif

package sync_fifo_wr_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
  localparam int DEF_NUM_REQ    = `WR_ARB_NUM_REQ;
  localparam int DEF_MAX_BEATS  = `WR_ARB_MAX_BEATS;

  typedef enum logic {
    ARB_IDLE = `ARB_IDLE,
    ARB_BUSY = `ARB_BUSY
  } arb_state_e;

  function automatic int unsigned wrap_inc(
    input int unsigned v,
    input int unsigned n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start,
// wrapping modulo N.
module sync_fifo_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back toward start so the
  // nearest hit is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(start) + i) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Packet-locking round-robin arbiter sharing the FIFO write port
// between NUM_REQ producers.
module sync_fifo_wr_arbiter
  import sync_fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BEATS  = DEF_MAX_BEATS,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_valid,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_full,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          grant_busy
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_e          state, state_d;
  logic [ID_WIDTH-1:0] owner, owner_d;
  logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  busy;
  logic                  xfer;
  logic                  last_beat;
  logic                  rel;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  sync_fifo_wr_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_rr_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy = (state == ARB_BUSY);

  // Reset gates the write side so nothing lands in the FIFO
  // during the cycle a grant is abandoned.
  always_comb begin
    req_ready = '0;
    wr_valid  = busy & ~reset & req_valid[owner];
    wr_data   = data_arr[owner];
    if (busy && !reset && !wr_full) begin
      req_ready[owner] = 1'b1;
    end
  end

  assign xfer      = wr_valid & ~wr_full;
  assign last_beat = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign rel       = xfer & (req_last[owner] | last_beat);

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    beat_cnt_d = beat_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_BUSY;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ARB_BUSY: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt + 1'b1;
        end
        if (rel) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = ID_WIDTH'(wrap_inc(int'(owner), NUM_REQ));
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      rr_ptr   <= rr_ptr_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  assign grant_id   = owner;
  assign grant_busy = busy;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Self-checking bench for sync_fifo_wr_arbiter: requester model,
// write scoreboard, arbitration vector table and corner sequences.
module tb_sync_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              wr_valid;
  logic [DW-1:0]     wr_data;
  logic              wr_full;
  logic [1:0]        grant_id;
  logic              grant_busy;

  always #5 clk = ~clk;

  sync_fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_full    (wr_full),
    .grant_id   (grant_id),
    .grant_busy (grant_busy)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } wexp_t;

  typedef struct {
    logic [3:0] mask;
    int         exp_id;
    int         exp_rr;
  } arb_vec_t;

  logic [8:0] mem [NR][16];
  int         head [NR];
  int         tail [NR];
  bit         en [NR];
  wexp_t      expq [$];
  int         errors = 0;
  int         checks = 0;
  arb_vec_t   tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && head[i] < tail[i]) begin
        req_valid[i]            = 1'b1;
        req_data[i*DW +: DW]    = mem[i][head[i]][7:0];
        req_last[i]             = mem[i][head[i]][8];
      end else begin
        req_valid[i]            = 1'b0;
        req_data[i*DW +: DW]    = '0;
        req_last[i]             = 1'b0;
      end
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
      en[i]   = 1'b1;
    end
    expq.delete();
  endtask

  task automatic load(input int r, input int n, input logic [7:0] base,
                      input bit push);
    logic [7:0] d;
    wexp_t      e;
    for (int k = 0; k < n; k++) begin
      d = base + 8'(k);
      mem[r][tail[r]] = {(k == n - 1), d};
      tail[r]++;
      if (push) begin
        e.id   = 2'(r);
        e.data = d;
        expq.push_back(e);
      end
    end
  endtask

  task automatic expect_w(input int r, input logic [7:0] d);
    wexp_t e;
    e.id   = 2'(r);
    e.data = d;
    expq.push_back(e);
  endtask

  // One clock: observe handshakes mid-cycle, advance requesters after
  // the edge, then present the next words.
  task automatic cyc();
    int    hs;
    int    hid;
    bit    adv [NR];
    wexp_t e;
    @(negedge clk);
    hs  = 0;
    hid = 0;
    for (int i = 0; i < NR; i++) begin
      adv[i] = 1'b0;
      if (req_valid[i] && req_ready[i]) begin
        hs++;
        hid    = i;
        adv[i] = 1'b1;
      end
    end
    if (hs > 1) begin
      checks++;
      errors++;
      $display("FAIL multi_accept: got %0d accepts expected 1", hs);
    end
    if (hs == 1) begin
      chk("wr_valid_on_accept", 32'(wr_valid), 32'd1);
      chk("wr_data_vs_head", 32'(wr_data), 32'(mem[hid][head[hid]][7:0]));
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got id %0d data %0h expected none",
                 hid, wr_data);
      end else begin
        e = expq.pop_front();
        chk("write_id", 32'(hid), 32'(e.id));
        chk("write_data", 32'(wr_data), 32'(e.data));
      end
    end else if (wr_valid && !wr_full) begin
      checks++;
      errors++;
      $display("FAIL write_without_accept: got wr_valid 1 expected 0");
    end
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      if (adv[i]) head[i]++;
    end
    #1;
    drive();
  endtask

  task automatic drain(input int exp_cycles, input string name);
    int n;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      cyc();
      n++;
    end
    chk({name, "_left"}, 32'(expq.size()), 32'd0);
    chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    wr_full = 1'b0;
    clear_q();
    drive();
    cyc();
    cyc();
    #1;
    chk("rst_busy", 32'(grant_busy), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rr", 32'(dut.rr_ptr), 32'd0);
    chk("rst_beat", 32'(dut.beat_cnt), 32'd0);
    reset = 1'b0;

    // single requester
    clear_q();
    load(2, 3, 8'hA1, 1'b1);
    drive();
    #1;
    chk("single_arb_busy", 32'(grant_busy), 32'd0);
    chk("single_arb_wv", 32'(wr_valid), 32'd0);
    cyc();
    #1;
    chk("single_grant_id", 32'(grant_id), 32'd2);
    chk("single_grant_busy", 32'(grant_busy), 32'd1);
    drain(3, "single");
    #1;
    chk("single_idle", 32'(grant_busy), 32'd0);
    chk("single_rr", 32'(dut.rr_ptr), 32'd3);

    // round robin, two 1-word packets per requester
    do_reset();
    clear_q();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NR; r++) begin
        load(r, 1, 8'(16 * r + k), 1'b1);
      end
    end
    drive();
    drain(16, "rr");

    // full stall mid-packet
    clear_q();
    load(1, 3, 8'hB1, 1'b1);
    drive();
    cyc();
    cyc();
    wr_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_wv", 32'(wr_valid), 32'd1);
      chk("stall_beat", 32'(dut.beat_cnt), 32'd1);
      cyc();
    end
    wr_full = 1'b0;
    drain(2, "stall");

    // forced release after MB beats
    clear_q();
    load(0, 6, 8'hC0, 1'b0);
    load(1, 2, 8'hD0, 1'b0);
    for (int k = 0; k < 4; k++) expect_w(0, 8'hC0 + 8'(k));
    expect_w(1, 8'hD0);
    expect_w(1, 8'hD1);
    expect_w(0, 8'hC4);
    expect_w(0, 8'hC5);
    drive();
    drain(11, "forced");

    // reset after word 2 of a 5-word packet
    clear_q();
    load(3, 5, 8'hE0, 1'b0);
    expect_w(3, 8'hE0);
    expect_w(3, 8'hE1);
    drive();
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    load(1, 1, 8'hF0, 1'b0);
    drive();
    #1;
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    chk("rstmid_wv", 32'(wr_valid), 32'd0);
    expect_w(1, 8'hF0);
    for (int k = 2; k < 5; k++) expect_w(3, 8'hE0 + 8'(k));
    cyc();
    reset = 1'b0;
    #1;
    chk("rstmid_busy", 32'(grant_busy), 32'd0);
    chk("rstmid_rr", 32'(dut.rr_ptr), 32'd0);
    chk("rstmid_id", 32'(grant_id), 32'd0);
    drain(6, "rstmid");

    // bubble inside a packet
    clear_q();
    load(2, 4, 8'h60, 1'b1);
    drive();
    cyc();
    cyc();
    en[2] = 1'b0;
    load(0, 1, 8'h70, 1'b1);
    load(1, 1, 8'h80, 1'b1);
    drive();
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bubble_wv", 32'(wr_valid), 32'd0);
      chk("bubble_id", 32'(grant_id), 32'd2);
      chk("bubble_busy", 32'(grant_busy), 32'd1);
      cyc();
    end
    en[2] = 1'b1;
    drive();
    drain(7, "bubble");

    // arbitration vector table from a fresh reset
    tbl[0] = '{4'b0110, 1, 2};
    tbl[1] = '{4'b1011, 3, 0};
    tbl[2] = '{4'b1000, 3, 0};
    tbl[3] = '{4'b0011, 0, 1};
    tbl[4] = '{4'b0001, 0, 1};
    tbl[5] = '{4'b1101, 2, 3};
    tbl[6] = '{4'b0111, 0, 1};
    tbl[7] = '{4'b1111, 1, 2};
    do_reset();
    for (int t = 0; t < 8; t++) begin
      clear_q();
      for (int r = 0; r < NR; r++) begin
        if (tbl[t].mask[r]) load(r, 1, 8'h90 + 8'(r), 1'b0);
      end
      expect_w(tbl[t].exp_id, 8'h90 + 8'(tbl[t].exp_id));
      drive();
      cyc();
      #1;
      chk($sformatf("tbl%0d_id", t), 32'(grant_id), 32'(tbl[t].exp_id));
      cyc();
      chk($sformatf("tbl%0d_left", t), 32'(expq.size()), 32'd0);
      clear_q();
      drive();
      #1;
      chk($sformatf("tbl%0d_rr", t), 32'(dut.rr_ptr), 32'(tbl[t].exp_rr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
